// File: rtl/demux8bit2_stream.sv
// Registered 1-to-2 byte demultiplexer: steers a valid/ready byte stream into
// two independent FIFO-buffered channels (A: sel=0, B: sel=1) with saturating byte counters.
module demux8bit2_stream #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [7:0]       b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Index 0 is channel A, index 1 is channel B.
  logic [7:0]       mem_q  [2][DEPTH];
  logic [PW-1:0]    wptr_q [2];
  logic [PW-1:0]    wptr_d [2];
  logic [PW-1:0]    rptr_q [2];
  logic [PW-1:0]    rptr_d [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] cnt_d  [2];

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;
  logic       accept;

  always_comb begin
    for (int unsigned ch = 0; ch < 2; ch++) begin
      empty[ch] = (wptr_q[ch] == rptr_q[ch]);
      full[ch]  = (wptr_q[ch][AW] != rptr_q[ch][AW]) &&
                  (wptr_q[ch][AW-1:0] == rptr_q[ch][AW-1:0]);
    end
  end

  // Ready looks only at occupancy sampled at this edge: a same-cycle pop never frees a slot.
  assign in_ready  = ~rst & (in_sel ? ~full[1] : ~full[0]);
  assign accept    = in_valid & in_ready;
  assign push      = {accept & in_sel, accept & ~in_sel};
  assign out_ready = {b_ready, a_ready};
  assign pop       = out_ready & ~empty;

  always_comb begin
    for (int unsigned ch = 0; ch < 2; ch++) begin
      wptr_d[ch] = push[ch] ? wptr_q[ch] + PW'(1) : wptr_q[ch];
      rptr_d[ch] = pop[ch]  ? rptr_q[ch] + PW'(1) : rptr_q[ch];
      cnt_d[ch]  = cnt_q[ch];
      if (push[ch] && (cnt_q[ch] != '1)) begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        wptr_q[ch] <= '0;
        rptr_q[ch] <= '0;
        cnt_q[ch]  <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem_q[ch][i] <= '0;
        end
      end
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        wptr_q[ch] <= wptr_d[ch];
        rptr_q[ch] <= rptr_d[ch];
        cnt_q[ch]  <= cnt_d[ch];
        if (push[ch]) begin
          mem_q[ch][wptr_q[ch][AW-1:0]] <= in_data;
        end
      end
    end
  end

  assign a_data  = mem_q[0][rptr_q[0][AW-1:0]];
  assign b_data  = mem_q[1][rptr_q[1][AW-1:0]];
  assign a_valid = ~empty[0];
  assign b_valid = ~empty[1];
  assign cnt_a   = cnt_q[0];
  assign cnt_b   = cnt_q[1];

endmodule

// File: doc/demux8bit2_stream.md
Name: demux8bit2_stream

Overview:
- Registered 1-to-2 byte demultiplexer: the receiving-side counterpart of the team's 8-bit 2:1 select mux.
- Accepts an 8-bit stream with a per-byte select bit and steers each byte into one of two buffered output channels (A for sel=0, B for sel=1).
- Uses valid/ready handshakes on all three interfaces.
- Keeps per-channel byte counters for debug and bring-up.

Parameters:
- DEPTH, 2: entries per output FIFO. Power of two, minimum 2.
- CNT_W, 16: width of each per-channel byte counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  input byte.
- in_sel  input  1  destination of the byte: 0 = channel A, 1 = channel B.
- in_valid  input  1  upstream has a byte on in_data/in_sel.
- in_ready  output  1  block can accept the presented byte.
- a_data  output  8  head byte of the channel A FIFO.
- a_valid  output  1  channel A FIFO is non-empty.
- a_ready  input  1  downstream A consumes the head byte.
- b_data  output  8  head byte of the channel B FIFO.
- b_valid  output  1  channel B FIFO is non-empty.
- b_ready  input  1  downstream B consumes the head byte.
- cnt_a  output  CNT_W  bytes accepted into channel A since reset; saturating.
- cnt_b  output  CNT_W  bytes accepted into channel B since reset; saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - Both FIFOs empty, pointers cleared.
  - a_valid=0, b_valid=0, cnt_a=0, cnt_b=0.
  - a_data/b_data read 8'h00.
  - Takes effect immediately, mid-transfer included; in-flight bytes are discarded.
  - in_ready=0 while rst is high.
- Handshakes:
  - in_ready = ~rst & (in_sel ? ~full_b : ~full_a).
  - Combinational from in_sel and FIFO state only; never depends on in_valid or the output readys.
  - Accept = in_valid & in_ready, sampled at the rising edge of clk.
  - Accepted byte is written to the tail of the selected FIFO. The other FIFO is untouched.
  - Upstream must hold in_data/in_sel stable while in_valid=1 and in_ready=0.
- Output channels:
  - X_valid = FIFO X non-empty.
  - X_data = head entry, driven from registered storage.
  - Pop = X_valid & X_ready at the clock edge.
  - X_ready while X_valid=0 has no effect.
- Latency:
  - Byte accepted at edge N is visible on X_data/X_valid after edge N.
  - It can be consumed at edge N+1 at the earliest.
  - No combinational path from input to output.
- Ordering:
  - Bytes on each channel leave in acceptance order.
  - No ordering between channels.
- Full channel:
  - A full channel stalls only input bytes that select it.
  - The other channel keeps draining independently.
  - No bypass: a full FIFO that is popped in the same cycle still shows in_ready=0 that cycle. One bubble.
- Simultaneous events:
  - Push and pop of the same non-full, non-empty FIFO in one cycle leaves the occupancy unchanged.
  - Push into an empty FIFO with X_ready high: the byte is not popped that cycle, since X_valid was 0.
- Pointers:
  - log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
  - full = MSBs differ and low bits equal.
  - empty = pointers equal.
- Counters:
  - cnt_a increments on each accept with in_sel=0; cnt_b on each accept with in_sel=1.
  - Each saturates at all-ones and never wraps.
  - Only reset clears them.

Test Plan:
- Reset then idle: after rst deassert, a_valid=b_valid=0, cnt_a=cnt_b=0, in_ready=1 for either sel.
- Route/order: send 8'h11(sel0), 8'h22(sel1), 8'h33(sel0) with both readys high.
  - A emits 11 then 33; B emits 22.
  - cnt_a=2, cnt_b=1.
  - Each byte valid one cycle after its accept.
- Backpressure, DEPTH=2: hold a_ready=0 and push 8'hA0, 8'hA1 to A.
  - in_ready drops to 0 for sel=0 but stays 1 for sel=1.
  - 8'hB0 to B passes through.
  - Releasing a_ready yields A0, A1 in order.
- Full-with-pop: A full, in_valid=1 sel=0, a_ready=1.
  - in_ready=0 that cycle (no bypass); A0 is popped.
  - Next cycle in_ready=1 and the new byte is accepted.
- Saturation, CNT_W=4: push 20 bytes to B with b_ready=1.
  - cnt_b sticks at 4'hF; cnt_a stays 0.
- Async reset mid-stream: assert rst between clock edges with both FIFOs holding data.
  - a_valid/b_valid/in_ready go 0 immediately; counters read 0.
  - After release, the first pushed byte appears alone with no stale data.
